state_vec_packer: RTL and testbench
===================================

STATE_VEC_PACKER -- requirements
Module: state_vec_packer

Interface
REQ-001 The module SHALL have parameter n, default 3: qubit count, giving N_AMPS = 2**n amplitudes per state vector.
REQ-002 The module SHALL have parameter w, default 2: width in bits of each signed real and imaginary part, giving an amplitude slot of 2*w bits.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port clr, input, 1 bit: synchronous soft clear, abandoning the vector in progress.
REQ-006 The module SHALL have port in_valid, input, 1 bit: an amplitude is offered.
REQ-007 The module SHALL have port in_ready, output, 1 bit: the packer accepts an amplitude this cycle.
REQ-008 The module SHALL have port in_re, input, w bits: real part, signed.
REQ-009 The module SHALL have port in_im, input, w bits: imaginary part, signed.
REQ-010 The module SHALL have port in_last, input, 1 bit: marks the final amplitude of a vector.
REQ-011 The module SHALL have port out_valid, output, 1 bit: a complete packed vector is presented.
REQ-012 The module SHALL have port out_ready, input, 1 bit: the consumer takes the vector.
REQ-013 The module SHALL have port out_vec, output, N_AMPS*2*w bits: the packed state vector.
REQ-014 The module SHALL have port fill_lvl, output, n+1 bits: number of amplitudes accepted into the current vector.
REQ-015 The module SHALL have port err, output, 1 bit: sticky in_last framing error.

Function
REQ-016 An input transfer SHALL occur when in_valid && in_ready are both high; an output transfer SHALL occur when out_valid && out_ready are both high.
REQ-017 Amplitude index i (the i-th accepted amplitude, 0-based) SHALL be written to out_vec[(N_AMPS-1-i)*2*w +: 2*w], so index 0 occupies the MSB slot.
REQ-018 Within a slot, in_re SHALL occupy the upper w bits and in_im the lower w bits; values SHALL be stored unmodified, with no extension or arithmetic.
REQ-019 The FSM SHALL have exactly two states: FILL (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-020 In FILL, each input transfer SHALL write one slot and increment fill_lvl.
REQ-021 In FILL, a transfer with in_last=1, or the transfer that brings fill_lvl to N_AMPS, SHALL move the FSM to HOLD on the next edge.
REQ-022 The out_valid signal SHALL assert in the cycle after the closing input transfer, giving a latency of 1 cycle.
REQ-023 In HOLD, out_vec and fill_lvl SHALL remain stable until the output transfer.
REQ-024 On the output transfer the FSM SHALL go to FILL, fill_lvl SHALL go to 0, and out_vec SHALL clear to 0, so that unwritten slots of a short vector read 0.
REQ-025 The in_ready signal SHALL be 0 in HOLD; no amplitude of the next vector is accepted in the output-transfer cycle.
REQ-026 Early in_last (fill_lvl+1 < N_AMPS) SHALL close the vector with the remaining slots at 0 and set err.
REQ-027 Missing in_last on the N_AMPS-th amplitude SHALL still close the vector and set err.
REQ-028 The err output, once set, SHALL remain 1 until rst or clr.
REQ-029 The clr input SHALL produce the same effect as rst on the next edge, including clearing err, and SHALL take priority over a simultaneous input or output transfer; the transfer is discarded.
REQ-030 When in_valid is low in FILL, no state or slot SHALL change.

Reset
REQ-031 On rst=1 at a clock edge: state FILL, out_vec=0, fill_lvl=0, err=0, out_valid=0.
REQ-032 While rst=1, in_ready SHALL be 0; it SHALL be 1 from the first cycle after rst deasserts.
REQ-033 A reset asserted mid-FILL or mid-HOLD SHALL discard the vector, with no output transfer reported.

Structure
REQ-034 Shared package qft_pkg SHALL hold: N_QUBITS, AMP_W, N_AMPS, VEC_W constants; a packed amplitude struct (re, im, signed AMP_W each); and the FSM state enum.
REQ-035 No sub-module SHALL be used; the FSM, the slot-write decode and the counter SHALL be implemented inline.
REQ-036 The block SHALL be the producer side for packed-vector consumers, using the same slot ordering.

Verification (n=3, w=2)
REQ-037 Scenario: stream amplitudes with slot value i (re=i[3:2], im=i[1:0]) for i=0..7, in_last on i=7, out_ready=1 -> out_vec=32'h01234567, out_valid 1 cycle after the 8th transfer, err=0.
REQ-038 Scenario: slot values 1,2,3 with in_last on the 3rd -> out_vec=32'h12300000, fill_lvl=3, err=1.
REQ-039 Scenario: full vector with no in_last -> vector presented, err=1; err stays 1 through the next clean vector until clr.
REQ-040 Scenario: backpressure, out_ready=0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0, out_vec and fill_lvl unchanged, exactly one output transfer when out_ready rises.
REQ-041 Scenario: clr after 4 amplitudes, asserted together with in_valid -> fill_lvl=0, out_vec=0; the following 8-amplitude vector packs correctly.
REQ-042 Scenario: rst in HOLD -> out_valid=0 and out_vec=0 next cycle; in_ready=0 while rst is high and 1 after.

Source files
------------

// File: rtl/qft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qft_pkg
//  Description : Shared constants and types for packed state-vector blocks.
//                Slot layout: index 0 in the MSB slot, real part above
//                imaginary part inside each slot.
//  Revision    : 1.0  initial release
// ============================================================================
package qft_pkg;

  localparam int N_QUBITS = 3;
  localparam int AMP_W    = 2;
  localparam int N_AMPS   = 2 ** N_QUBITS;
  localparam int VEC_W    = N_AMPS * 2 * AMP_W;

  // One amplitude slot exactly as it sits inside a packed vector.
  typedef struct packed {
    logic signed [AMP_W-1:0] re;
    logic signed [AMP_W-1:0] im;
  } amp_t;

  // FILL accepts amplitudes, HOLD presents the finished vector.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

endpackage
`default_nettype wire

// File: rtl/state_vec_packer.sv
`default_nettype none
// ============================================================================
//  Module      : state_vec_packer
//  Description : Collects a stream of complex amplitudes into one packed
//                state vector, presents it with valid/ready, and flags
//                in_last framing errors (sticky until rst or clr).
//  Revision    : 1.0  initial release
// ============================================================================
module state_vec_packer
  import qft_pkg::*;
#(
  parameter int n = N_QUBITS,
  parameter int w = AMP_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [w-1:0]       in_re,
  input  logic signed [w-1:0]       in_im,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [(2**n)*2*w-1:0]     out_vec,
  output logic [n:0]                fill_lvl,
  output logic                      err
);

  localparam int          SLOTS    = 2 ** n;
  localparam int          SLOT_W   = 2 * w;
  localparam logic [n:0]  LAST_IDX = (n+1)'(SLOTS - 1);

  pack_state_t                r_state;
  pack_state_t                w_state_next;
  logic [SLOTS*SLOT_W-1:0]    r_vec;
  logic [SLOTS*SLOT_W-1:0]    w_vec_next;
  logic [n:0]                 r_fill;
  logic                       r_err;
  logic [SLOTS-1:0]           w_sel;
  logic                       w_in_xfer;
  logic                       w_out_xfer;
  logic                       w_at_last;
  logic                       w_close;

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;
  assign w_at_last  = (r_fill == LAST_IDX);
  // A vector closes on in_last or when its final slot is filled.
  assign w_close    = w_in_xfer && (in_last || w_at_last);

  // One-hot decode of the slot addressed by the current fill level.
  generate
    for (genvar g = 0; g < SLOTS; g++) begin : g_slot_sel
      assign w_sel[g] = (r_fill == (n+1)'(g));
    end
  endgenerate

  // State register; clr behaves exactly like rst.
  always_ff @(posedge clk) begin
    if (rst || clr) r_state <= FILL;
    else            r_state <= w_state_next;
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FILL:    if (w_close)    w_state_next = HOLD;
      HOLD:    if (w_out_xfer) w_state_next = FILL;
      default: w_state_next = FILL;
    endcase
  end

  // Handshake outputs; in_ready is held low while rst is asserted.
  always_comb begin
    in_ready  = (r_state == FILL) && !rst;
    out_valid = (r_state == HOLD);
  end

  // Slot write or clear-on-consume; unwritten slots stay zero.
  always_comb begin
    w_vec_next = r_vec;
    if (w_out_xfer) begin
      w_vec_next = '0;
    end else if (w_in_xfer) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (w_sel[i]) w_vec_next[(SLOTS-1-i)*SLOT_W +: SLOT_W] = {in_re, in_im};
      end
    end
  end

  // Vector, fill counter and sticky framing error.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_vec  <= '0;
      r_fill <= '0;
      r_err  <= 1'b0;
    end else begin
      r_vec <= w_vec_next;
      if (w_out_xfer)     r_fill <= '0;
      else if (w_in_xfer) r_fill <= r_fill + 1'b1;
      // Early in_last, or no in_last on the final slot, is a framing error.
      if (w_in_xfer && (in_last ^ w_at_last)) r_err <= 1'b1;
    end
  end

  assign out_vec  = r_vec;
  assign fill_lvl = r_fill;
  assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_state_vec_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_state_vec_packer
//  Description : Self-checking bench for state_vec_packer (n=3, w=2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_state_vec_packer;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_last, out_ready;
  logic [1:0]  in_re, in_im;
  logic        in_ready, out_valid, err;
  logic [31:0] out_vec;
  logic [3:0]  fill_lvl;

  always #5 clk = ~clk;

  state_vec_packer #(.n(3), .w(2)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .fill_lvl(fill_lvl), .err(err)
  );

  typedef struct packed {
    logic [31:0] vec;
    logic [3:0]  fill;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_vec;
  int          m_fill;
  logic        m_err;
  int          checks   = 0;
  int          failures = 0;

  task automatic model_clear();
    m_vec  = '0;
    m_fill = 0;
    m_err  = 1'b0;
    sb.delete();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_clear();
  endtask

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic push_amp(input logic [3:0] v, input logic last);
    int   k;
    exp_t e;
    k = 0;
    in_valid = 1'b1; in_re = v[3:2]; in_im = v[1:0]; in_last = last;
    @(negedge clk);
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL push_timeout in_ready=%b required=1", in_ready);
    end else begin
      m_vec[(7-m_fill)*4 +: 4] = v;
      m_fill++;
      if (last && m_fill < 8)   m_err = 1'b1;
      if (!last && m_fill == 8) m_err = 1'b1;
      if (last || m_fill == 8) begin
        e.vec = m_vec; e.fill = 4'(m_fill); e.err = m_err;
        sb.push_back(e);
        m_vec = '0; m_fill = 0;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; in_re = '0; in_im = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_vec !== 32'h0) begin failures++; $display("FAIL reset_out_vec got=%h exp=0", out_vec); end
    checks++; if (fill_lvl !== 4'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill_lvl); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    model_clear();
    @(posedge clk); #1;
  endtask

  task automatic test_full_vector();
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_amp(4'(i), i == 7);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL full_latency out_valid=%b exp=1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_vec !== 32'h01234567) begin failures++; $display("FAIL full_vec_const got=%h exp=01234567", out_vec); end
    checks++;
    if (sb.size() == 0) begin
      failures++; $display("FAIL full_sb_empty got=0 entries exp=1");
    end else begin
      e = sb.pop_front();
      if (out_vec !== e.vec || fill_lvl !== e.fill || err !== e.err) begin
        failures++;
        $display("FAIL full_sb got=%h/%0d/%b exp=%h/%0d/%b", out_vec, fill_lvl, err, e.vec, e.fill, e.err);
      end
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_vec !== 32'h0 || fill_lvl !== 4'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_consume got valid=%b vec=%h fill=%0d rdy=%b exp 0/0/0/1", out_valid, out_vec, fill_lvl, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_early_last();
    exp_t e;
    out_ready = 1'b0;
    push_amp(4'd1, 1'b0); push_amp(4'd2, 1'b0); push_amp(4'd3, 1'b1);
    @(negedge clk);
    checks++; if (out_vec !== 32'h12300000) begin failures++; $display("FAIL early_vec got=%h exp=12300000", out_vec); end
    checks++; if (fill_lvl !== 4'd3) begin failures++; $display("FAIL early_fill got=%0d exp=3", fill_lvl); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL early_err got=%b exp=1", err); end
    checks++;
    if (sb.size() == 0) begin
      failures++; $display("FAIL early_sb_empty got=0 entries exp=1");
    end else begin
      e = sb.pop_front();
      if (out_vec !== e.vec || fill_lvl !== e.fill || err !== e.err || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL early_sb got=%h/%0d/%b exp=%h/%0d/%b", out_vec, fill_lvl, err, e.vec, e.fill, e.err);
      end
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_vec !== 32'h0 || err !== 1'b1) begin
      failures++;
      $display("FAIL early_after got valid=%b vec=%h err=%b exp 0/0/1", out_valid, out_vec, err);
    end
    @(posedge clk); #1;
    pulse_clr();
    @(negedge clk);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL early_clr_err got=%b exp=0", err); end
    @(posedge clk); #1;
  endtask

  task automatic test_missing_last();
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_amp(4'(8 + i), 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_vec !== 32'h89ABCDEF || err !== 1'b1) begin
      failures++;
      $display("FAIL missing_vec got valid=%b vec=%h err=%b exp 1/89abcdef/1", out_valid, out_vec, err);
    end
    if (sb.size() != 0) e = sb.pop_front();
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) push_amp(4'(7 - i), i == 7);
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      failures++; $display("FAIL missing_sb_empty got=0 entries exp=1");
    end else begin
      e = sb.pop_front();
      if (out_vec !== e.vec || err !== e.err || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL missing_sticky got=%h/%b exp=%h/%b", out_vec, err, e.vec, e.err);
      end
    end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL missing_err_sticky got=%b exp=1", err); end
    @(posedge clk); #1;
    pulse_clr();
    @(negedge clk);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL missing_clr_err got=%b exp=0", err); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   nx;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_amp(4'(15 - i), i == 7);
    e = '0;
    if (sb.size() != 0) e = sb.pop_front();
    in_valid = 1'b1; in_re = 2'd3; in_im = 2'd3; in_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_vec !== e.vec || out_vec !== 32'hFEDCBA98 || fill_lvl !== 4'd8) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got rdy=%b v=%b vec=%h fill=%0d exp 0/1/fedcba98/8", c, in_ready, out_valid, out_vec, fill_lvl);
      end
    end
    @(posedge clk); #1; out_ready = 1'b1;
    nx = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        nx++;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_xfer_in_ready got=%b exp=0", in_ready); end
      end
    end
    checks++; if (nx != 1) begin failures++; $display("FAIL bp_xfer_count got=%0d exp=1", nx); end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    pulse_clr();
    @(negedge clk);
    checks++; if (fill_lvl !== 4'd0) begin failures++; $display("FAIL bp_clr_fill got=%0d exp=0", fill_lvl); end
    @(posedge clk); #1;
  endtask

  task automatic test_clr();
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_amp(4'hA, 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_re = 2'd1; in_im = 2'd1; in_last = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    model_clear();
    @(negedge clk);
    checks++; if (fill_lvl !== 4'd0 || out_vec !== 32'h0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL clr_state got fill=%0d vec=%h v=%b exp 0/0/0", fill_lvl, out_vec, out_valid);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) push_amp(4'(i + 3), i == 7);
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      failures++; $display("FAIL clr_sb_empty got=0 entries exp=1");
    end else begin
      e = sb.pop_front();
      if (out_vec !== e.vec || out_vec !== 32'h3456789A || fill_lvl !== 4'd8 || err !== 1'b0) begin
        failures++;
        $display("FAIL clr_repack got=%h/%0d/%b exp=3456789a/8/0", out_vec, fill_lvl, err);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) push_amp(4'(i * 5 + 2), (i % 8) == 7);
      end
      begin
        int   got;
        int   cyc;
        exp_t e;
        got = 0; cyc = 0;
        while (got < 2 && cyc < 120) begin
          @(negedge clk);
          cyc++;
          if (out_valid && out_ready) begin
            got++;
            checks++;
            if (sb.size() == 0) begin
              failures++; $display("FAIL b2b_sb_empty got=0 entries exp=1");
            end else begin
              e = sb.pop_front();
              if (out_vec !== e.vec || fill_lvl !== e.fill || err !== e.err) begin
                failures++;
                $display("FAIL b2b_vec got=%h/%0d/%b exp=%h/%0d/%b", out_vec, fill_lvl, err, e.vec, e.fill, e.err);
              end
            end
          end
        end
        checks++; if (got != 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", got); end
      end
    join
    @(posedge clk); #1;
  endtask

  task automatic test_rst_hold();
    exp_t e;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_amp(4'(i ^ 5), i == 7);
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      failures++; $display("FAIL rst_sb_empty got=0 entries exp=1");
    end else begin
      e = sb.pop_front();
      if (out_valid !== 1'b1 || out_vec !== e.vec) begin
        failures++; $display("FAIL rst_pre_hold got=%b/%h exp=1/%h", out_valid, out_vec, e.vec);
      end
    end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready_during got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_vec !== 32'h0 || fill_lvl !== 4'd0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_hold got v=%b vec=%h fill=%0d rdy=%b exp 0/0/0/0", out_valid, out_vec, fill_lvl, in_ready);
    end
    @(posedge clk); #1; rst = 1'b0;
    model_clear();
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_release got rdy=%b v=%b exp 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_full_vector();
    test_early_last();
    test_missing_last();
    test_backpressure();
    test_clr();
    test_back_to_back();
    test_rst_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
